// File: rtl/axilite_pkg.sv
// Shared types and address decode for the AXI-lite memory backend.
`timescale 1ns/1ps
package axilite_pkg;

  typedef enum logic [1:0] {
    IDLE,
    BUSY_W,
    BUSY_R
  } state_t;

  typedef enum logic {
    GRANT_READ,
    GRANT_WRITE
  } grant_t;

  localparam int unsigned DEF_ADDR_W         = 32;
  localparam int unsigned DEF_DATA_W         = 64;
  localparam logic [63:0] DEF_MEM_ADDR_START = 64'h1000_0000;
  localparam int unsigned DEF_MEM_ADDR_RANGE = 5;

  typedef struct packed {
    logic        hit;
    logic [31:0] index;
  } decode_t;

  // Low address bits below the word size drop out in the shift.
  function automatic decode_t addr_decode(
    input logic [63:0] addr,
    input logic [63:0] start,
    input int unsigned range_words,
    input int unsigned word_bytes_log2
  );
    logic [63:0] off;
    decode_t     d;
    off     = addr - start;
    d.hit   = (addr >= start) && (off < (64'(range_words) << word_bytes_log2));
    d.index = 32'(off >> word_bytes_log2);
    return d;
  endfunction

endpackage

// File: rtl/axilite_regfile.sv
// Byte-strobed word array with one synchronous read/write port.
`timescale 1ns/1ps
module axilite_regfile #(
  parameter int unsigned DATA_W = 64,
  parameter int unsigned DEPTH  = 5,
  parameter int unsigned IDX_W  = 3
) (
  input  logic                aclk,
  input  logic                aresetn,
  input  logic                en,
  input  logic                we,
  input  logic [IDX_W-1:0]    addr,
  input  logic [DATA_W-1:0]   wdata,
  input  logic [DATA_W/8-1:0] wstrb,
  output logic [DATA_W-1:0]   rdata
);

  logic [DATA_W-1:0] mem [DEPTH];

  // NOTE: the array is cleared on reset because never-written words must read back as 0.
  always_ff @(posedge aclk) begin
    if (!aresetn) begin
      for (int i = 0; i < int'(DEPTH); i++) mem[i] <= '0;
      rdata <= '0;
    end else if (en) begin
      if (we) begin
        for (int b = 0; b < int'(DATA_W / 8); b++) begin
          if (wstrb[b]) mem[addr][b*8 +: 8] <= wdata[b*8 +: 8];
        end
      end else begin
        rdata <= mem[addr];
      end
    end
  end

endmodule

// File: rtl/axilite_mem_backend.sv
// Memory-side responder: arbitrates read/write requests onto one storage port with fixed latency.
`timescale 1ns/1ps
module axilite_mem_backend
  import axilite_pkg::*;
#(
  parameter int unsigned ADDR_W         = DEF_ADDR_W,
  parameter int unsigned DATA_W         = DEF_DATA_W,
  parameter logic [63:0] MEM_ADDR_START = DEF_MEM_ADDR_START,
  parameter int unsigned MEM_ADDR_RANGE = DEF_MEM_ADDR_RANGE,
  parameter int unsigned ACCESS_LAT     = 1
) (
  input  logic                aclk,
  input  logic                aresetn,
  input  logic                mem_w_req,
  output logic                mem_w_ack,
  input  logic [ADDR_W-1:0]   mem_w_addr,
  input  logic [DATA_W-1:0]   mem_w_data,
  input  logic [DATA_W/8-1:0] mem_w_strb,
  input  logic                mem_r_req,
  output logic                mem_r_ack,
  input  logic [ADDR_W-1:0]   mem_r_addr,
  output logic [DATA_W-1:0]   mem_r_data,
  output logic                mem_w_decerr,
  output logic                mem_r_decerr
);

  localparam int unsigned STRB_W    = DATA_W / 8;
  localparam int unsigned BYTE_LOG2 = $clog2(STRB_W);
  localparam int unsigned IDX_W     = (MEM_ADDR_RANGE > 1) ? $clog2(MEM_ADDR_RANGE) : 1;
  localparam int unsigned CNT_W     = (ACCESS_LAT > 1) ? $clog2(ACCESS_LAT) : 1;
  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(ACCESS_LAT - 1);

  state_t              state;
  grant_t              last_grant;
  logic [CNT_W-1:0]    cnt;
  logic                w_done, r_done;
  logic                hit_q, r_hit_q;
  logic [31:0]         idx_q;
  logic [DATA_W-1:0]   wdata_q;
  logic [STRB_W-1:0]   strb_q;

  logic                w_pend, r_pend, complete;
  logic                grant_w, grant_r;
  decode_t             dec;
  logic                rf_en, rf_we;
  logic [DATA_W-1:0]   rf_rdata;

  assign w_pend   = mem_w_req & ~w_done;
  assign r_pend   = mem_r_req & ~r_done;
  assign complete = (state != IDLE) && (cnt == '0);

  // The completion cycle hands the port straight to the other side if it is waiting.
  // NOTE: every output gets a default first so no path through the block infers a latch.
  always_comb begin
    grant_w = 1'b0;
    grant_r = 1'b0;
    unique case (state)
      IDLE: begin
        if (w_pend && (!r_pend || last_grant == GRANT_READ)) grant_w = 1'b1;
        else if (r_pend)                                     grant_r = 1'b1;
      end
      BUSY_W:  grant_r = complete && r_pend;
      BUSY_R:  grant_w = complete && w_pend;
      default: ;
    endcase
  end

  always_comb begin
    dec = addr_decode(64'(grant_w ? mem_w_addr : mem_r_addr), MEM_ADDR_START,
                      MEM_ADDR_RANGE, BYTE_LOG2);
  end

  // NOTE: non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge aclk) begin
    if (!aresetn) begin
      state        <= IDLE;
      last_grant   <= GRANT_READ;
      cnt          <= '0;
      w_done       <= 1'b0;
      r_done       <= 1'b0;
      hit_q        <= 1'b0;
      r_hit_q      <= 1'b0;
      idx_q        <= '0;
      wdata_q      <= '0;
      strb_q       <= '0;
      mem_w_decerr <= 1'b0;
      mem_r_decerr <= 1'b0;
    end else begin
      mem_w_decerr <= 1'b0;
      mem_r_decerr <= 1'b0;
      if (!mem_w_req) w_done <= 1'b0;
      if (!mem_r_req) r_done <= 1'b0;

      if (state != IDLE) begin
        if (cnt == '0) begin
          state <= IDLE;
          if (state == BUSY_W) begin
            w_done       <= 1'b1;
            mem_w_decerr <= ~hit_q;
          end else begin
            r_done       <= 1'b1;
            mem_r_decerr <= ~hit_q;
            r_hit_q      <= hit_q;
          end
        end else begin
          cnt <= cnt - CNT_W'(1);
        end
      end

      if (grant_w || grant_r) begin
        state      <= grant_w ? BUSY_W : BUSY_R;
        last_grant <= grant_w ? GRANT_WRITE : GRANT_READ;
        cnt        <= CNT_LOAD;
        hit_q      <= dec.hit;
        idx_q      <= dec.index;
        if (grant_w) begin
          wdata_q <= mem_w_data;
          strb_q  <= mem_w_strb;
        end
      end
    end
  end

  assign rf_en = complete && hit_q && (idx_q < 32'(MEM_ADDR_RANGE));
  assign rf_we = (state == BUSY_W);

  axilite_regfile #(
    .DATA_W (DATA_W),
    .DEPTH  (MEM_ADDR_RANGE),
    .IDX_W  (IDX_W)
  ) u_regfile (
    .aclk    (aclk),
    .aresetn (aresetn),
    .en      (rf_en),
    .we      (rf_we),
    .addr    (idx_q[IDX_W-1:0]),
    .wdata   (wdata_q),
    .wstrb   (strb_q),
    .rdata   (rf_rdata)
  );

  // The regfile output only moves on a read, so held data ignores later writes.
  assign mem_r_data = r_hit_q ? rf_rdata : '0;
  assign mem_w_ack  = w_done & mem_w_req;
  assign mem_r_ack  = r_done & mem_r_req;

endmodule

// File: tb/tb_axilite_mem_backend.sv
// Bench for axilite_mem_backend: three latency variants checked against a transaction-level model.
`timescale 1ns/1ps
module tb_axilite_mem_backend;

  localparam int N = 3;
  localparam logic [31:0] START = 32'h1000_0000;
  localparam int WORDS = 5;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rstn   [N];
  logic        w_req  [N];
  logic [31:0] w_addr [N];
  logic [63:0] w_data [N];
  logic [7:0]  w_strb [N];
  logic        r_req  [N];
  logic [31:0] r_addr [N];
  logic        w_ack  [N];
  logic        r_ack  [N];
  logic [63:0] r_data [N];
  logic        w_dec  [N];
  logic        r_dec  [N];

  axilite_mem_backend #(.ADDR_W(32), .DATA_W(64), .MEM_ADDR_START(64'h1000_0000),
                        .MEM_ADDR_RANGE(5), .ACCESS_LAT(1)) u_lat1 (
    .aclk(clk), .aresetn(rstn[0]),
    .mem_w_req(w_req[0]), .mem_w_ack(w_ack[0]), .mem_w_addr(w_addr[0]),
    .mem_w_data(w_data[0]), .mem_w_strb(w_strb[0]),
    .mem_r_req(r_req[0]), .mem_r_ack(r_ack[0]), .mem_r_addr(r_addr[0]),
    .mem_r_data(r_data[0]), .mem_w_decerr(w_dec[0]), .mem_r_decerr(r_dec[0]));

  axilite_mem_backend #(.ADDR_W(32), .DATA_W(64), .MEM_ADDR_START(64'h1000_0000),
                        .MEM_ADDR_RANGE(5), .ACCESS_LAT(3)) u_lat3 (
    .aclk(clk), .aresetn(rstn[1]),
    .mem_w_req(w_req[1]), .mem_w_ack(w_ack[1]), .mem_w_addr(w_addr[1]),
    .mem_w_data(w_data[1]), .mem_w_strb(w_strb[1]),
    .mem_r_req(r_req[1]), .mem_r_ack(r_ack[1]), .mem_r_addr(r_addr[1]),
    .mem_r_data(r_data[1]), .mem_w_decerr(w_dec[1]), .mem_r_decerr(r_dec[1]));

  axilite_mem_backend #(.ADDR_W(32), .DATA_W(64), .MEM_ADDR_START(64'h1000_0000),
                        .MEM_ADDR_RANGE(5), .ACCESS_LAT(4)) u_lat4 (
    .aclk(clk), .aresetn(rstn[2]),
    .mem_w_req(w_req[2]), .mem_w_ack(w_ack[2]), .mem_w_addr(w_addr[2]),
    .mem_w_data(w_data[2]), .mem_w_strb(w_strb[2]),
    .mem_r_req(r_req[2]), .mem_r_ack(r_ack[2]), .mem_r_addr(r_addr[2]),
    .mem_r_data(r_data[2]), .mem_w_decerr(w_dec[2]), .mem_r_decerr(r_dec[2]));

  int checks = 0;
  int failures = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic int lat_of(input int k);
    case (k)
      0:       return 1;
      1:       return 3;
      default: return 4;
    endcase
  endfunction

  function automatic bit model_hit(input logic [31:0] a);
    return (a >= START) && (a < START + 32'(WORDS * 8));
  endfunction

  function automatic int model_idx(input logic [31:0] a);
    return int'((a - START) / 8);
  endfunction

  // Transaction-level model: the port is either free or owned by one job that
  // finishes at a known edge; a freed port is reassigned on the same edge.
  localparam int JOB_NONE = 0, JOB_WR = 1, JOB_RD = 2;

  logic [63:0] m_mem  [N][WORDS];
  bit          m_wdone[N], m_rdone[N], m_last_w[N], m_wdec[N], m_rdec[N];
  int          m_job  [N], m_fin[N];
  logic [31:0] m_addr [N];
  logic [63:0] m_data [N], m_rdata[N];
  logic [7:0]  m_strb [N];
  int          cyc = 0;
  bit          cmp_en = 0;
  int          wdec_cnt[N], rdec_cnt[N];

  initial forever begin
    @(posedge clk);
    cyc++;
    for (int k = 0; k < N; k++) begin
      if (!rstn[k]) begin
        for (int i = 0; i < WORDS; i++) m_mem[k][i] = '0;
        m_wdone[k] = 0; m_rdone[k] = 0; m_last_w[k] = 0;
        m_wdec[k] = 0;  m_rdec[k] = 0;  m_job[k] = JOB_NONE;
        m_rdata[k] = '0;
      end else begin
        bit wp, rp;
        wp = w_req[k] && !m_wdone[k];
        rp = r_req[k] && !m_rdone[k];
        m_wdec[k] = 0;
        m_rdec[k] = 0;
        if (!w_req[k]) m_wdone[k] = 0;
        if (!r_req[k]) m_rdone[k] = 0;
        if (m_job[k] != JOB_NONE && cyc == m_fin[k]) begin
          if (m_job[k] == JOB_WR) begin
            if (model_hit(m_addr[k])) begin
              for (int b = 0; b < 8; b++)
                if (m_strb[k][b]) m_mem[k][model_idx(m_addr[k])][b*8 +: 8] = m_data[k][b*8 +: 8];
            end else m_wdec[k] = 1;
            m_wdone[k] = 1;
            wp = 0;
          end else begin
            if (model_hit(m_addr[k])) m_rdata[k] = m_mem[k][model_idx(m_addr[k])];
            else begin
              m_rdata[k] = '0;
              m_rdec[k]  = 1;
            end
            m_rdone[k] = 1;
            rp = 0;
          end
          m_job[k] = JOB_NONE;
        end
        if (m_job[k] == JOB_NONE && (wp || rp)) begin
          if (wp && (!rp || !m_last_w[k])) begin
            m_job[k] = JOB_WR; m_addr[k] = w_addr[k];
            m_data[k] = w_data[k]; m_strb[k] = w_strb[k]; m_last_w[k] = 1;
          end else begin
            m_job[k] = JOB_RD; m_addr[k] = r_addr[k]; m_last_w[k] = 0;
          end
          m_fin[k] = cyc + lat_of(k);
        end
      end
    end
  end

  initial forever begin
    @(negedge clk);
    if (cmp_en) begin
      for (int k = 0; k < N; k++) begin
        check($sformatf("w_ack[%0d]", k),  64'(w_ack[k]), 64'(m_wdone[k] & w_req[k]));
        check($sformatf("r_ack[%0d]", k),  64'(r_ack[k]), 64'(m_rdone[k] & r_req[k]));
        check($sformatf("w_dec[%0d]", k),  64'(w_dec[k]), 64'(m_wdec[k]));
        check($sformatf("r_dec[%0d]", k),  64'(r_dec[k]), 64'(m_rdec[k]));
        check($sformatf("r_data[%0d]", k), r_data[k], m_rdata[k]);
        wdec_cnt[k] += int'(w_dec[k]);
        rdec_cnt[k] += int'(r_dec[k]);
      end
    end
  end

  task automatic do_write(input int k, input logic [31:0] a, input logic [63:0] d,
                          input logic [7:0] s, output int lat);
    int e0;
    @(posedge clk); #1;
    w_addr[k] = a; w_data[k] = d; w_strb[k] = s; w_req[k] = 1'b1;
    e0  = cyc;
    lat = -1;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (w_ack[k]) begin
        lat = cyc - e0 - 1;
        break;
      end
    end
    @(posedge clk); #1;
    w_req[k] = 1'b0;
  endtask

  task automatic do_read(input int k, input logic [31:0] a, output logic [63:0] d, output int lat);
    int e0;
    @(posedge clk); #1;
    r_addr[k] = a; r_req[k] = 1'b1;
    e0  = cyc;
    lat = -1;
    d   = 'x;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (r_ack[k]) begin
        lat = cyc - e0 - 1;
        d   = r_data[k];
        break;
      end
    end
    @(posedge clk); #1;
    r_req[k] = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    logic [63:0] d;
    int lat, wl, rl, held, acks, e0;
    bit rd_seen;

    for (int k = 0; k < N; k++) begin
      rstn[k] = 1'b0; w_req[k] = 1'b0; r_req[k] = 1'b0;
      w_addr[k] = '0; w_data[k] = '0; w_strb[k] = '0; r_addr[k] = '0;
      wdec_cnt[k] = 0; rdec_cnt[k] = 0;
    end
    repeat (3) @(posedge clk);
    #1;
    for (int k = 0; k < N; k++) rstn[k] = 1'b1;
    cmp_en = 1;
    @(negedge clk);
    for (int k = 0; k < N; k++) begin
      check($sformatf("reset w_ack[%0d]", k),  64'(w_ack[k]), 64'd0);
      check($sformatf("reset r_ack[%0d]", k),  64'(r_ack[k]), 64'd0);
      check($sformatf("reset r_data[%0d]", k), r_data[k], 64'd0);
    end

    // Write then read, LAT=1
    do_write(0, 32'h1000_0008, 64'hDEAD_BEEF_CAFE_F00D, 8'hFF, lat);
    check("wr1 latency", 64'(lat), 64'd1);
    do_read(0, 32'h1000_0008, d, lat);
    check("rd1 latency", 64'(lat), 64'd1);
    check("rd1 data", d, 64'hDEAD_BEEF_CAFE_F00D);

    // Partial strobe clears only the low four bytes
    do_write(0, 32'h1000_0008, 64'h0, 8'h0F, lat);
    do_read(0, 32'h1000_0008, d, lat);
    check("partial strobe data", d, 64'hDEAD_BEEF_0000_0000);

    // Last word, unaligned read address
    do_write(0, 32'h1000_0020, 64'h0123_4567_89AB_CDEF, 8'hFF, lat);
    do_read(0, 32'h1000_0024, d, lat);
    check("last word unaligned read", d, 64'h0123_4567_89AB_CDEF);

    // Out of range on both sides
    do_write(0, 32'h1000_0028, 64'hFFFF_FFFF_FFFF_FFFF, 8'hFF, lat);
    check("oor write acked", 64'(lat), 64'd1);
    do_read(0, 32'h0FFF_FFF8, d, lat);
    check("oor read acked", 64'(lat), 64'd1);
    check("oor read data", d, 64'd0);
    check("w_decerr pulses", 64'(wdec_cnt[0]), 64'd1);
    check("r_decerr pulses", 64'(rdec_cnt[0]), 64'd1);
    do_read(0, 32'h1000_0008, d, lat);
    check("storage unchanged w1", d, 64'hDEAD_BEEF_0000_0000);
    do_read(0, 32'h1000_0020, d, lat);
    check("storage unchanged w4", d, 64'h0123_4567_89AB_CDEF);

    // Held write ack while a read is served
    @(posedge clk); #1;
    w_addr[0] = START; w_data[0] = 64'hA5A5_5A5A_0F0F_F0F0; w_strb[0] = 8'hFF; w_req[0] = 1'b1;
    e0 = cyc; lat = -1;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (w_ack[0]) begin
        lat = cyc - e0 - 1;
        break;
      end
    end
    check("held wr latency", 64'(lat), 64'd1);
    @(posedge clk); #1;
    r_addr[0] = START; r_req[0] = 1'b1;
    held = 0; rd_seen = 0; d = 'x;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (w_ack[0]) held++;
      if (r_ack[0] && !rd_seen) begin
        rd_seen = 1;
        d = r_data[0];
      end
    end
    check("w_ack held 10 cycles", 64'(held), 64'd10);
    check("read served during held ack", 64'(rd_seen), 64'd1);
    check("read during held ack data", d, 64'hA5A5_5A5A_0F0F_F0F0);
    @(posedge clk); #1;
    w_req[0] = 1'b0; r_req[0] = 1'b0;
    #1;
    check("w_ack drops with req", 64'(w_ack[0]), 64'd0);

    // Simultaneous requests, LAT=3: write wins the first tie
    @(posedge clk); #1;
    w_addr[1] = 32'h1000_0010; w_data[1] = 64'h1122_3344_5566_7788; w_strb[1] = 8'hFF;
    r_addr[1] = 32'h1000_0010;
    w_req[1] = 1'b1; r_req[1] = 1'b1;
    e0 = cyc; wl = -1; rl = -1; d = 'x;
    for (int i = 0; i < 30; i++) begin
      @(negedge clk);
      if (w_ack[1] && wl < 0) wl = cyc - e0 - 1;
      if (r_ack[1] && rl < 0) begin
        rl = cyc - e0 - 1;
        d  = r_data[1];
      end
      if (wl >= 0 && rl >= 0) break;
    end
    check("tie write latency", 64'(wl), 64'd3);
    check("tie read latency", 64'(rl), 64'd6);
    check("tie read sees new data", d, 64'h1122_3344_5566_7788);
    @(posedge clk); #1;
    w_req[1] = 1'b0; r_req[1] = 1'b0;

    // Reset one cycle into BUSY_W, LAT=4
    @(posedge clk); #1;
    w_addr[2] = 32'h1000_0018; w_data[2] = 64'hFEED_FACE_1234_5678; w_strb[2] = 8'hFF;
    w_req[2] = 1'b1;
    acks = 0;
    @(negedge clk); acks += int'(w_ack[2]);
    @(posedge clk); #1;
    @(negedge clk); acks += int'(w_ack[2]);
    @(posedge clk); #1;
    rstn[2] = 1'b0; w_req[2] = 1'b0;
    repeat (2) begin
      @(negedge clk); acks += int'(w_ack[2]);
      @(posedge clk); #1;
    end
    rstn[2] = 1'b1;
    repeat (6) begin
      @(negedge clk); acks += int'(w_ack[2]);
    end
    check("no ack after mid-access reset", 64'(acks), 64'd0);
    do_read(2, 32'h1000_0018, d, lat);
    check("post-reset read latency", 64'(lat), 64'd4);
    check("post-reset word is zero", d, 64'd0);

    repeat (3) @(posedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
